// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and the execution stage that consumes it.
package instr_register_pkg;

  typedef logic [4:0]         address_t;
  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;

  // Opcodes are 4 bits wide so that encodings 8..15 exist as undefined instructions.
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic [2:0] exec_state_t;

  localparam exec_state_t S_IDLE  = 3'd0;
  localparam exec_state_t S_FETCH = 3'd1;
  localparam exec_state_t S_EXEC  = 3'd2;
  localparam exec_state_t S_DIVW  = 3'd3;
  localparam exec_state_t S_OUT   = 3'd4;
  localparam exec_state_t S_DONE  = 3'd5;

  function automatic result_t sext32(input operand_t v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/instr_divider.sv
// Iterative restoring signed divider: one quotient bit per cycle, done DIV_CYCLES cycles after start.
module instr_divider #(
  parameter int DIV_CYCLES = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic signed [DIV_CYCLES-1:0] dividend,
  input  logic signed [DIV_CYCLES-1:0] divisor,
  output logic                         busy,
  output logic                         done,
  output logic signed [DIV_CYCLES:0]   quotient,
  output logic signed [DIV_CYCLES-1:0] remainder
);

  localparam int W  = DIV_CYCLES;
  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [W:0]    r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_dvs;
  logic          r_neg_q;
  logic          r_neg_r;

  logic [W-1:0]  w_abs_a;
  logic [W-1:0]  w_abs_b;
  logic [2*W:0]  w_first;
  logic [2*W:0]  w_next;

  // Returns {remainder, quotient} after shifting in one more dividend bit.
  function automatic logic [2*W:0] div_step(input logic [W:0] rem, input logic [W-1:0] quo,
                                            input logic [W-1:0] dvs);
    logic [W:0] shifted;
    logic [W:0] diff;
    shifted = {rem[W-1:0], quo[W-1]};
    diff    = shifted - {1'b0, dvs};
    if (!diff[W]) return {diff, quo[W-2:0], 1'b1};
    else          return {shifted, quo[W-2:0], 1'b0};
  endfunction

  assign w_abs_a = dividend[W-1] ? (~$unsigned(dividend) + 1'b1) : $unsigned(dividend);
  assign w_abs_b = divisor[W-1]  ? (~$unsigned(divisor) + 1'b1)  : $unsigned(divisor);
  assign w_first = div_step('0, w_abs_a, w_abs_b);
  assign w_next  = div_step(r_rem, r_quo, r_dvs);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(1);
    end else if (r_busy) begin
      if (r_cnt == CW'(DIV_CYCLES)) r_busy <= 1'b0;
      else                          r_cnt  <= r_cnt + 1'b1;
    end
  end

  // The launch edge already performs the first iteration so the last bit lands on cycle DIV_CYCLES.
  always_ff @(posedge clk) begin
    if (start) begin
      r_rem   <= w_first[2*W:W];
      r_quo   <= w_first[W-1:0];
      r_dvs   <= w_abs_b;
      r_neg_q <= dividend[W-1] ^ divisor[W-1];
      r_neg_r <= dividend[W-1];
    end else if (r_busy && (r_cnt != CW'(DIV_CYCLES))) begin
      r_rem <= w_next[2*W:W];
      r_quo <= w_next[W-1:0];
    end
  end

  assign busy      = r_busy;
  assign done      = r_busy && (r_cnt == CW'(DIV_CYCLES));
  assign quotient  = r_neg_q ? -$signed({1'b0, r_quo}) : $signed({1'b0, r_quo});
  assign remainder = r_neg_r ? -$signed(r_rem[W-1:0]) : $signed(r_rem[W-1:0]);

endmodule

// File: rtl/instr_exec_unit.sv
// Execution stage: walks the instruction register, computes each result and streams it out.
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         first_addr,
  input  logic [5:0]         num_instr,
  output logic [4:0]         read_pointer,
  input  instruction_t       instruction_word,
  output logic               busy,
  output logic               done,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [4:0]         res_addr,
  output logic signed [63:0] res_data,
  output logic               res_div0
);

  exec_state_t  r_state;
  address_t     r_ptr;
  logic [5:0]   r_cnt;
  logic         r_busy;
  logic         r_res_valid;
  address_t     r_res_addr;
  result_t      r_res_data;
  logic         r_res_div0;
  instruction_t r_instr;

  logic                         w_is_div;
  logic                         w_div_by0;
  logic                         w_div_start;
  logic                         w_div_busy;
  logic                         w_div_done;
  logic signed [DIV_CYCLES:0]   w_quo;
  logic signed [DIV_CYCLES-1:0] w_rem;
  result_t                      w_div_res;

  function automatic result_t alu(input instruction_t ins);
    result_t a;
    result_t b;
    a = sext32(ins.op_a);
    b = sext32(ins.op_b);
    case (ins.opc)
      PASSA:   return a;
      PASSB:   return b;
      ADD:     return a + b;
      SUB:     return a - b;
      MULT:    return a * b;
      default: return '0;
    endcase
  endfunction

  assign w_is_div    = (r_instr.opc == DIV) || (r_instr.opc == MOD);
  assign w_div_by0   = (r_instr.op_b == '0);
  assign w_div_start = (r_state == S_EXEC) && w_is_div && !w_div_by0 && !w_div_busy;

  instr_divider #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (w_div_start),
    .dividend  (r_instr.op_a),
    .divisor   (r_instr.op_b),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  assign w_div_res = (r_instr.opc == DIV)
                   ? {{(64-DIV_CYCLES-1){w_quo[DIV_CYCLES]}}, w_quo}
                   : {{(64-DIV_CYCLES){w_rem[DIV_CYCLES-1]}}, w_rem};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_addr  <= '0;
      r_res_data  <= '0;
      r_res_div0  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ptr   <= first_addr;
            r_cnt   <= num_instr;
            r_busy  <= 1'b1;
            r_state <= (num_instr == 6'd0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: r_state <= S_EXEC;
        S_EXEC: begin
          r_res_addr <= r_ptr;
          if (w_is_div && !w_div_by0) begin
            r_state <= S_DIVW;
          end else begin
            r_res_data  <= w_is_div ? '0 : alu(r_instr);
            r_res_div0  <= w_is_div;
            r_res_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_DIVW: begin
          if (w_div_done) begin
            r_res_data  <= w_div_res;
            r_res_div0  <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_ptr       <= r_ptr + 1'b1;
            r_cnt       <= r_cnt - 1'b1;
            r_state     <= (r_cnt > 6'd1) ? S_FETCH : S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand register is pure data and is overwritten on every fetch.
  always_ff @(posedge clk) begin
    if (r_state == S_FETCH) r_instr <= instruction_word;
  end

  assign read_pointer = r_ptr;
  assign busy         = r_busy;
  assign done         = (r_state == S_DONE);
  assign res_valid    = r_res_valid;
  assign res_addr     = r_res_addr;
  assign res_data     = r_res_data;
  assign res_div0     = r_res_div0;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: table-driven single-instruction runs plus multi-cycle sequences.
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  localparam int DIV_CYCLES = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [4:0]         first_addr;
  logic [5:0]         num_instr;
  logic [4:0]         read_pointer;
  instruction_t       instruction_word;
  logic               busy;
  logic               done;
  logic               res_valid;
  logic               res_ready;
  logic [4:0]         res_addr;
  logic signed [63:0] res_data;
  logic               res_div0;

  instruction_t mem [32];

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
    logic        div0;
  } beat_t;

  typedef struct {
    opcode_t     opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    logic        div0;
    int          lat;
  } vec_t;

  beat_t sb[$];
  vec_t  vt[16];
  int    n_cmp   = 0;
  int    n_err   = 0;
  int    n_beats = 0;

  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [4:0]  prev_addr;

  always #5 clk = ~clk;
  assign instruction_word = mem[read_pointer];

  instr_exec_unit #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .first_addr       (first_addr),
    .num_instr        (num_instr),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .busy             (busy),
    .done             (done),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_addr         (res_addr),
    .res_data         (res_data),
    .res_div0         (res_div0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && res_valid) begin
        chk("hold_data", res_data, prev_data);
        chk("hold_addr", {59'd0, res_addr}, {59'd0, prev_addr});
      end
      if (res_valid && res_ready) begin
        n_beats++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got addr %0d data %h, expected no beat", res_addr, res_data);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_addr", {59'd0, res_addr}, {59'd0, e.addr});
          chk("beat_data", res_data, e.data);
          chk("beat_div0", {63'd0, res_div0}, {63'd0, e.div0});
        end
      end
      prev_stall = res_valid && !res_ready;
      prev_data  = res_data;
      prev_addr  = res_addr;
    end
  end

  // Launches a run and waits (bounded) for done; lat is the cycle of the first valid beat.
  task automatic do_run(input logic [4:0] fa, input logic [5:0] n, input bit tog, output int lat);
    int cyc;
    @(posedge clk); #1;
    first_addr = fa;
    num_instr  = n;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    lat   = -1;
    while (!done && cyc < 800) begin
      if (res_valid && lat < 0) lat = cyc;
      if (tog) res_ready = ~res_ready;
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_pulse", {63'd0, done}, 64'd0);
    chk("busy_after", {63'd0, busy}, 64'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"},  {63'd0, busy},      64'd0);
    chk({tag, "_done"},  {63'd0, done},      64'd0);
    chk({tag, "_valid"}, {63'd0, res_valid}, 64'd0);
    chk({tag, "_rptr"},  {59'd0, read_pointer}, 64'd0);
    chk({tag, "_addr"},  {59'd0, res_addr},  64'd0);
    chk({tag, "_data"},  res_data,           64'd0);
    chk({tag, "_div0"},  {63'd0, res_div0},  64'd0);
  endtask

  initial begin
    int lat;
    int b0;
    logic [4:0] ad;
    bit ok;

    vt[0]  = '{ADD,   32'd5,          -32'sd7,       64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3};
    vt[1]  = '{MULT,  32'h7FFF_FFFF,  32'd2,         64'h0000_0000_FFFF_FFFE, 1'b0, 3};
    vt[2]  = '{SUB,   32'h8000_0000,  32'd1,         64'hFFFF_FFFF_7FFF_FFFF, 1'b0, 3};
    vt[3]  = '{DIV,   -32'sd7,        32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0, DIV_CYCLES + 3};
    vt[4]  = '{MOD,   -32'sd7,        32'd2,         64'hFFFF_FFFF_FFFF_FFFF, 1'b0, DIV_CYCLES + 3};
    vt[5]  = '{DIV,   32'd9,          32'd0,         64'd0,                   1'b1, 3};
    vt[6]  = '{MOD,   32'd9,          32'd0,         64'd0,                   1'b1, 3};
    vt[7]  = '{DIV,   32'h8000_0000,  32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, DIV_CYCLES + 3};
    vt[8]  = '{ZERO,  32'd3,          32'd4,         64'd0,                   1'b0, 3};
    vt[9]  = '{PASSA, -32'sd5,        32'd4,         64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 3};
    vt[10] = '{PASSB, 32'd1,          32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0, 3};
    vt[11] = '{opcode_t'(4'd9), 32'd3, 32'd4,        64'd0,                   1'b0, 3};
    vt[12] = '{MULT,  -32'sd3,        32'd4,         64'hFFFF_FFFF_FFFF_FFF4, 1'b0, 3};
    vt[13] = '{MOD,   32'd7,          -32'sd2,       64'd1,                   1'b0, DIV_CYCLES + 3};
    vt[14] = '{DIV,   32'd7,          -32'sd2,       64'hFFFF_FFFF_FFFF_FFFD, 1'b0, DIV_CYCLES + 3};
    vt[15] = '{MULT,  32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 3};

    for (int i = 0; i < 32; i++) mem[i] = '{ZERO, 32'd0, 32'd0};
    reset = 1'b1; start = 1'b0; res_ready = 1'b1; first_addr = '0; num_instr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    reset = 1'b0;

    // Reset in the middle of a divide abandons the run and drops the beat.
    mem[7] = '{DIV, 32'd100, 32'd3};
    first_addr = 5'd7; num_instr = 6'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", {63'd0, busy}, 64'd1);
    chk("mid_addr", {59'd0, res_addr}, 64'd7);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_zero_outputs("midrst");
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_nobeat", n_beats, 64'd0);
    sb.push_back('{5'd7, 64'd33, 1'b0});
    do_run(5'd7, 6'd1, 1'b0, lat);
    chk("midrst_rerun_lat", lat, DIV_CYCLES + 3);
    chk("midrst_rerun_sb", sb.size(), 64'd0);

    for (int i = 0; i < 16; i++) begin
      ad = 5'(i + 2);
      mem[ad] = '{opc: vt[i].opc, op_a: vt[i].a, op_b: vt[i].b};
      sb.push_back('{ad, vt[i].exp, vt[i].div0});
      b0 = n_beats;
      do_run(ad, 6'd1, 1'b0, lat);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_beats", i), n_beats - b0, 64'd1);
      chk($sformatf("vec%0d_sb", i), sb.size(), 64'd0);
    end

    // Address wrap with a throttled consumer.
    mem[30] = '{ADD, 32'd1, 32'd10};
    mem[31] = '{SUB, 32'd2, 32'd10};
    mem[0]  = '{MULT, 32'd3, 32'd10};
    mem[1]  = '{PASSA, 32'd4, 32'd10};
    sb.push_back('{5'd30, 64'd11, 1'b0});
    sb.push_back('{5'd31, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0});
    sb.push_back('{5'd0,  64'd30, 1'b0});
    sb.push_back('{5'd1,  64'd4,  1'b0});
    b0 = n_beats;
    do_run(5'd30, 6'd4, 1'b1, lat);
    chk("wrap_beats", n_beats - b0, 64'd4);
    chk("wrap_sb", sb.size(), 64'd0);

    b0 = n_beats;
    do_run(5'd5, 6'd0, 1'b0, lat);
    chk("zero_beats", n_beats - b0, 64'd0);
    chk("zero_nolat", {63'd0, lat == -1}, 64'd1);

    // start while busy and start coincident with done are both ignored.
    mem[10] = '{PASSA, 32'd77, 32'd0};
    mem[11] = '{PASSB, 32'd0, 32'd88};
    mem[20] = '{PASSA, 32'd99, 32'd0};
    sb.push_back('{5'd10, 64'd77, 1'b0});
    sb.push_back('{5'd11, 64'd88, 1'b0});
    b0 = n_beats;
    @(posedge clk); #1;
    first_addr = 5'd10; num_instr = 6'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    first_addr = 5'd20; num_instr = 6'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      if (done) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("busy_start_done", {63'd0, ok}, 64'd1);
    first_addr = 5'd20; num_instr = 6'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_start_busy", {63'd0, busy}, 64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("busy_start_beats", n_beats - b0, 64'd2);
    chk("busy_start_sb", sb.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
